// File: rtl/urp_pcie_rx_data_link_layer_pkg.sv
// Shared types and constants for the PCIe RX data link layer.
// Frame layout: W0 carries the sequence number, W1..W7 carry the TLP,
// and W8 is the trailer.
package urp_pcie_pkg;

  localparam int SEQ_W       = 12;
  localparam int TLP_WORDS   = 7;
  localparam int FRAME_WORDS = 9;
  localparam int WORD_W      = 32;
  localparam int TLP_W       = TLP_WORDS * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_TRAIL = 2'd2
  } rx_state_e;

  // A mismatching sequence that lies at most half the space behind NRS has
  // already been received, so it is a duplicate rather than a gap.
  function automatic logic seq_is_dup(input logic [SEQ_W-1:0] nrs,
                                      input logic [SEQ_W-1:0] seq);
    logic [SEQ_W-1:0] diff;
    diff = nrs - seq;
    return (diff <= 12'd2048);
  endfunction

endpackage

// File: rtl/urp_pcie_rx_ack_sched.sv
// ACK/NAK scheduler: coalesces delivery ACKs, suppresses repeated NAKs
// until the next delivery, and keeps one shadow request while the TX side
// stalls the ACK/NAK channel.
module urp_pcie_rx_ack_sched
  import urp_pcie_pkg::*;
#(
  parameter int ACK_FACTOR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             deliver_i,
  input  logic [SEQ_W-1:0] deliver_seq_i,
  input  logic             nak_req_i,
  input  logic             dup_ack_req_i,
  input  logic [SEQ_W-1:0] nrs_m1_i,
  input  logic             ack_ready_i,
  output logic             ack_valid_o,
  output logic             ack_nak_o,
  output logic [SEQ_W-1:0] ack_seq_o
);

  localparam logic [3:0] AF_M1 = 4'(ACK_FACTOR - 1);

  logic [3:0]       cnt_q, cnt_d;
  logic             nak_sched_q, nak_sched_d;
  logic             av_q, av_d;
  logic             an_q, an_d;
  logic [SEQ_W-1:0] as_q, as_d;
  logic             sv_q, sv_d;
  logic             sn_q, sn_d;
  logic [SEQ_W-1:0] ss_q, ss_d;

  logic             ack_go, nak_go, req_valid, req_nak;
  logic [SEQ_W-1:0] ack_seq, req_seq;

  // Request generation, coalescing and channel/shadow arbitration.
  always_comb begin
    cnt_d       = cnt_q;
    nak_sched_d = nak_sched_q;
    av_d        = av_q;
    an_d        = an_q;
    as_d        = as_q;
    sv_d        = sv_q;
    sn_d        = sn_q;
    ss_d        = ss_q;
    ack_go      = dup_ack_req_i;
    ack_seq     = nrs_m1_i;

    if (deliver_i) begin
      nak_sched_d = 1'b0;
      if (cnt_q == AF_M1) begin
        cnt_d   = 4'd0;
        ack_go  = 1'b1;
        ack_seq = deliver_seq_i;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    nak_go = nak_req_i && !nak_sched_q;
    if (nak_go) nak_sched_d = 1'b1;

    req_valid = ack_go || nak_go;
    req_nak   = nak_go;
    req_seq   = nak_go ? nrs_m1_i : ack_seq;

    if (!av_q || ack_ready_i) begin
      // Channel free next cycle: shadow goes first, new request backfills it.
      if (sv_q) begin
        av_d = 1'b1;
        an_d = sn_q;
        as_d = ss_q;
        sv_d = req_valid;
        sn_d = req_nak;
        ss_d = req_seq;
      end else if (req_valid) begin
        av_d = 1'b1;
        an_d = req_nak;
        as_d = req_seq;
      end else begin
        av_d = 1'b0;
      end
    end else if (req_valid && (!sv_q || !sn_q || req_nak)) begin
      // Stalled: keep latest request, but never let an ACK displace a NAK.
      sv_d = 1'b1;
      sn_d = req_nak;
      ss_d = req_seq;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      nak_sched_q <= 1'b0;
      av_q        <= 1'b0;
      an_q        <= 1'b0;
      as_q        <= '0;
      sv_q        <= 1'b0;
      sn_q        <= 1'b0;
      ss_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      nak_sched_q <= nak_sched_d;
      av_q        <= av_d;
      an_q        <= an_d;
      as_q        <= as_d;
      sv_q        <= sv_d;
      sn_q        <= sn_d;
      ss_q        <= ss_d;
    end
  end

  assign ack_valid_o = av_q;
  assign ack_nak_o   = an_q;
  assign ack_seq_o   = as_q;

endmodule

// File: rtl/urp_pcie_rx_data_link_layer.sv
// PCIe RX data link layer: deframes 9-word frames from the PHY, checks
// sequence (and optionally the trailer XOR), delivers TLPs and requests
// ACK/NAK DLLPs through the scheduler.
// Optional feature: define URP_PCIE_RX_LCRC_EN to compare W8 against the
// XOR of W0..W7; otherwise W8 only marks the frame end.
module urp_pcie_rx_data_link_layer
  import urp_pcie_pkg::*;
#(
  parameter int ACK_FACTOR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] phy_data_i,
  input  logic              phy_valid_i,
  input  logic              phy_sop_i,
  input  logic              phy_eop_i,
  output logic [TLP_W-1:0]  tlp_data_o,
  output logic              tlp_data_valid_o,
  input  logic              tlp_data_ready_i,
  output logic              ack_valid_o,
  output logic              ack_nak_o,
  output logic [SEQ_W-1:0]  ack_seq_o,
  input  logic              ack_ready_i,
  output logic [7:0]        err_cnt_o
);

  rx_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic [TLP_W-1:0]  frame_q, frame_d;
  logic [TLP_W-1:0]  tlp_q, tlp_d;
  logic              tlp_valid_q, tlp_valid_d;
  logic [SEQ_W-1:0]  nrs_q, nrs_d;
  logic [7:0]        err_q, err_d;

  logic              err_pulse, nak_req, dup_req, deliver, csum_ok, slot_free;
  logic [SEQ_W-1:0]  nrs_m1;

  assign nrs_m1 = nrs_q - 12'd1;

`ifdef URP_PCIE_RX_LCRC_EN
  assign csum_ok = (csum_q == phy_data_i);
`else
  assign csum_ok = 1'b1;
`endif

  // Deframing FSM, frame evaluation and delivery.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    csum_d      = csum_q;
    frame_d     = frame_q;
    tlp_d       = tlp_q;
    tlp_valid_d = tlp_valid_q;
    nrs_d       = nrs_q;
    err_pulse   = 1'b0;
    nak_req     = 1'b0;
    dup_req     = 1'b0;
    deliver     = 1'b0;
    slot_free   = !tlp_valid_q || tlp_data_ready_i;

    if (tlp_valid_q && tlp_data_ready_i) tlp_valid_d = 1'b0;

    if (phy_valid_i) begin
      if (phy_sop_i) begin
        if (state_q != ST_IDLE) err_pulse = 1'b1;
        if (phy_eop_i) begin
          err_pulse = 1'b1;
          nak_req   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          seq_d   = phy_data_i[SEQ_W-1:0];
          csum_d  = phy_data_i;
          cnt_d   = 3'd0;
          state_d = ST_DATA;
        end
      end else begin
        case (state_q)
          ST_DATA: begin
            if (phy_eop_i) begin
              err_pulse = 1'b1;
              nak_req   = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frame_d[TLP_W-1-WORD_W*int'(cnt_q) -: WORD_W] = phy_data_i;
              csum_d = csum_q ^ phy_data_i;
              cnt_d  = cnt_q + 3'd1;
              if (cnt_q == 3'(TLP_WORDS - 1)) state_d = ST_TRAIL;
            end
          end
          ST_TRAIL: begin
            state_d = ST_IDLE;
            if (!phy_eop_i || !csum_ok) begin
              err_pulse = 1'b1;
              nak_req   = 1'b1;
            end else if (seq_q == nrs_q) begin
              if (slot_free) begin
                deliver     = 1'b1;
                tlp_d       = frame_q;
                tlp_valid_d = 1'b1;
                nrs_d       = nrs_q + 12'd1;
              end else begin
                err_pulse = 1'b1;
                nak_req   = 1'b1;
              end
            end else if (seq_is_dup(nrs_q, seq_q)) begin
              dup_req = 1'b1;
            end else begin
              err_pulse = 1'b1;
              nak_req   = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    err_d = (err_pulse && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // Datapath and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seq_q       <= '0;
      csum_q      <= '0;
      frame_q     <= '0;
      tlp_q       <= '0;
      tlp_valid_q <= 1'b0;
      nrs_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      csum_q      <= csum_d;
      frame_q     <= frame_d;
      tlp_q       <= tlp_d;
      tlp_valid_q <= tlp_valid_d;
      nrs_q       <= nrs_d;
      err_q       <= err_d;
    end
  end

  urp_pcie_rx_ack_sched #(
    .ACK_FACTOR(ACK_FACTOR)
  ) u_ack_sched (
    .clk          (clk),
    .rst_n        (rst_n),
    .deliver_i    (deliver),
    .deliver_seq_i(seq_q),
    .nak_req_i    (nak_req),
    .dup_ack_req_i(dup_req),
    .nrs_m1_i     (nrs_m1),
    .ack_ready_i  (ack_ready_i),
    .ack_valid_o  (ack_valid_o),
    .ack_nak_o    (ack_nak_o),
    .ack_seq_o    (ack_seq_o)
  );

  assign tlp_data_o       = tlp_q;
  assign tlp_data_valid_o = tlp_valid_q;
  assign err_cnt_o        = err_q;

endmodule

// File: tb/tb_urp_pcie_rx_data_link_layer.sv
// Directed testbench for urp_pcie_rx_data_link_layer (default ACK_FACTOR
// instance plus an ACK_FACTOR=3 instance sharing the PHY stimulus).
module tb_urp_pcie_rx_data_link_layer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  phy_data = '0;
  logic         phy_valid = 1'b0, phy_sop = 1'b0, phy_eop = 1'b0;
  logic         tlp_ready = 1'b1, ack_ready = 1'b1;
  logic [223:0] tlp_data, tlp_data3;
  logic         tlp_valid, tlp_valid3;
  logic         ack_valid, ack_nak, ack_valid3, ack_nak3;
  logic [11:0]  ack_seq, ack_seq3;
  logic [7:0]   err_cnt, err_cnt3;
  int           n_cmp = 0, n_err = 0, ack3_fires = 0;

  always #5 clk = ~clk;

  urp_pcie_rx_data_link_layer dut (
    .clk(clk), .rst_n(rst_n), .phy_data_i(phy_data), .phy_valid_i(phy_valid),
    .phy_sop_i(phy_sop), .phy_eop_i(phy_eop), .tlp_data_o(tlp_data),
    .tlp_data_valid_o(tlp_valid), .tlp_data_ready_i(tlp_ready),
    .ack_valid_o(ack_valid), .ack_nak_o(ack_nak), .ack_seq_o(ack_seq),
    .ack_ready_i(ack_ready), .err_cnt_o(err_cnt));

  urp_pcie_rx_data_link_layer #(.ACK_FACTOR(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .phy_data_i(phy_data), .phy_valid_i(phy_valid),
    .phy_sop_i(phy_sop), .phy_eop_i(phy_eop), .tlp_data_o(tlp_data3),
    .tlp_data_valid_o(tlp_valid3), .tlp_data_ready_i(tlp_ready),
    .ack_valid_o(ack_valid3), .ack_nak_o(ack_nak3), .ack_seq_o(ack_seq3),
    .ack_ready_i(1'b1), .err_cnt_o(err_cnt3));

  always @(posedge clk) if (ack_valid3) ack3_fires <= ack3_fires + 1;

  function automatic logic [31:0] word_k(input int k, input logic [31:0] off);
    return (32'h11111111 * k) + off;
  endfunction

  function automatic logic [223:0] exp_tlp(input logic [31:0] off);
    logic [223:0] t;
    for (int k = 1; k <= 7; k++) t[223-32*(k-1) -: 32] = word_k(k, off);
    return t;
  endfunction

  function automatic logic [31:0] exp_xor(input logic [11:0] seq, input logic [31:0] off);
    logic [31:0] x;
    x = {20'h0, seq};
    for (int k = 1; k <= 7; k++) x = x ^ word_k(k, off);
    return x;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic s, input logic e);
    phy_data = d; phy_sop = s; phy_eop = e; phy_valid = 1'b1;
    @(posedge clk); #1;
    phy_valid = 1'b0; phy_sop = 1'b0; phy_eop = 1'b0;
  endtask

  task automatic send_body(input logic [11:0] seq, input logic [31:0] off);
    send_word({20'hABCDE, seq}, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) send_word(word_k(k, off), 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [11:0] seq, input logic [31:0] off, input bit bad);
    logic [31:0] x;
    x = exp_xor(seq, off) ^ {20'hABCDE, 12'h000};
    if (bad) x = x ^ 32'h1;
    send_body(seq, off);
    send_word(x, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    phy_valid = 1'b0; phy_sop = 1'b0; phy_eop = 1'b0;
    tlp_ready = 1'b1; ack_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #2;
    n_cmp++; if (tlp_valid !== 1'b0) begin n_err++; $display("FAIL rst_tlp_valid: got %b exp 0", tlp_valid); end
    n_cmp++; if (tlp_data !== 224'h0) begin n_err++; $display("FAIL rst_tlp_data: got %h exp 0", tlp_data); end
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== 14'h0) begin n_err++; $display("FAIL rst_ack: got %b/%b/%h exp 0/0/000", ack_valid, ack_nak, ack_seq); end
    n_cmp++; if (err_cnt !== 8'h0) begin n_err++; $display("FAIL rst_err: got %0d exp 0", err_cnt); end
    do_reset();
  endtask

  task automatic test_good_frame();
    do_reset();
    send_frame(12'd0, 32'h0, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1) begin n_err++; $display("FAIL good_valid: got %b exp 1", tlp_valid); end
    n_cmp++; if (tlp_data !== 224'h11111111_22222222_33333333_44444444_55555555_66666666_77777777) begin n_err++; $display("FAIL good_data: got %h", tlp_data); end
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b10, 12'h000}) begin n_err++; $display("FAIL good_ack: got %b/%b/%h exp 1/0/000", ack_valid, ack_nak, ack_seq); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL good_err: got %0d exp 0", err_cnt); end
    @(posedge clk); #1;
    n_cmp++; if (tlp_valid !== 1'b0 || ack_valid !== 1'b0) begin n_err++; $display("FAIL good_drain: got tlp %b ack %b exp 0 0", tlp_valid, ack_valid); end
    send_frame(12'd1, 32'h01010101, 1'b0);
    n_cmp++; if (tlp_data !== exp_tlp(32'h01010101) || ack_seq !== 12'd1) begin n_err++; $display("FAIL good_second: got seq %h data %h", ack_seq, tlp_data); end
  endtask

  task automatic test_bad_lcrc();
    do_reset();
    send_frame(12'd0, 32'h0, 1'b1);
`ifdef URP_PCIE_RX_LCRC_EN
    n_cmp++; if (tlp_valid !== 1'b0) begin n_err++; $display("FAIL lcrc_valid: got %b exp 0", tlp_valid); end
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b11, 12'hFFF}) begin n_err++; $display("FAIL lcrc_nak: got %b/%b/%h exp 1/1/fff", ack_valid, ack_nak, ack_seq); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_err++; $display("FAIL lcrc_err: got %0d exp 1", err_cnt); end
    send_frame(12'd0, 32'h0, 1'b1);
    n_cmp++; if (ack_valid !== 1'b0 || err_cnt !== 8'd2) begin n_err++; $display("FAIL lcrc_repeat: got ack %b err %0d exp 0 2", ack_valid, err_cnt); end
`else
    n_cmp++; if (tlp_valid !== 1'b1 || tlp_data !== exp_tlp(32'h0)) begin n_err++; $display("FAIL nolcrc_deliver: got %b %h", tlp_valid, tlp_data); end
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b10, 12'h000}) begin n_err++; $display("FAIL nolcrc_ack: got %b/%b/%h exp 1/0/000", ack_valid, ack_nak, ack_seq); end
    send_frame(12'd0, 32'h0, 1'b1);
    n_cmp++; if (tlp_valid !== 1'b0 || err_cnt !== 8'd0 || ack_seq !== 12'h000 || ack_nak !== 1'b0) begin n_err++; $display("FAIL nolcrc_dup: got v %b err %0d seq %h nak %b", tlp_valid, err_cnt, ack_seq, ack_nak); end
`endif
  endtask

  task automatic test_duplicate();
    do_reset();
    for (int s = 0; s < 5; s++) send_frame(12'(s), 32'h0, 1'b0);
    send_frame(12'd5, 32'h02020202, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || tlp_data !== exp_tlp(32'h02020202) || ack_seq !== 12'd5) begin n_err++; $display("FAIL dup_first: got v %b seq %h", tlp_valid, ack_seq); end
    send_frame(12'd5, 32'h03030303, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b0) begin n_err++; $display("FAIL dup_valid: got %b exp 0", tlp_valid); end
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b10, 12'd5}) begin n_err++; $display("FAIL dup_ack: got %b/%b/%h exp 1/0/005", ack_valid, ack_nak, ack_seq); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL dup_err: got %0d exp 0", err_cnt); end
  endtask

  task automatic test_ahead();
    do_reset();
    send_frame(12'd3, 32'h0, 1'b0);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b11, 12'hFFF} || err_cnt !== 8'd1) begin n_err++; $display("FAIL ahead_nak: got %b/%b/%h err %0d", ack_valid, ack_nak, ack_seq, err_cnt); end
    send_frame(12'd7, 32'h0, 1'b0);
    n_cmp++; if (ack_valid !== 1'b0 || err_cnt !== 8'd2) begin n_err++; $display("FAIL ahead_suppress: got ack %b err %0d exp 0 2", ack_valid, err_cnt); end
    send_frame(12'd0, 32'h0, 1'b0);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b10, 12'h000} || tlp_valid !== 1'b1) begin n_err++; $display("FAIL ahead_recover: got %b/%b/%h v %b", ack_valid, ack_nak, ack_seq, tlp_valid); end
    send_frame(12'd5, 32'h0, 1'b0);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b11, 12'h000} || err_cnt !== 8'd3) begin n_err++; $display("FAIL ahead_renak: got %b/%b/%h err %0d", ack_valid, ack_nak, ack_seq, err_cnt); end
    do_reset();
    send_frame(12'h800, 32'h0, 1'b0);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b10, 12'hFFF} || err_cnt !== 8'd0) begin n_err++; $display("FAIL dup_2048: got %b/%b/%h err %0d", ack_valid, ack_nak, ack_seq, err_cnt); end
    send_frame(12'h7FF, 32'h0, 1'b0);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b11, 12'hFFF} || err_cnt !== 8'd1) begin n_err++; $display("FAIL ahead_2049: got %b/%b/%h err %0d", ack_valid, ack_nak, ack_seq, err_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    tlp_ready = 1'b0;
    send_frame(12'd0, 32'h0, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || ack_seq !== 12'd0 || ack_nak !== 1'b0) begin n_err++; $display("FAIL bp_first: got v %b seq %h nak %b", tlp_valid, ack_seq, ack_nak); end
    send_frame(12'd1, 32'h05050505, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || tlp_data !== exp_tlp(32'h0)) begin n_err++; $display("FAIL bp_hold: got v %b data %h", tlp_valid, tlp_data); end
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b11, 12'd0} || err_cnt !== 8'd1) begin n_err++; $display("FAIL bp_nak: got %b/%b/%h err %0d", ack_valid, ack_nak, ack_seq, err_cnt); end
    tlp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (tlp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b exp 0", tlp_valid); end
    send_frame(12'd1, 32'h05050505, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || tlp_data !== exp_tlp(32'h05050505) || ack_seq !== 12'd1) begin n_err++; $display("FAIL bp_resend: got v %b seq %h", tlp_valid, ack_seq); end
  endtask

  task automatic test_framing();
    do_reset();
    send_word(32'hDEAD0000, 1'b0, 1'b0);
    send_word(32'hDEAD0001, 1'b0, 1'b1);
    n_cmp++; if (err_cnt !== 8'd0 || ack_valid !== 1'b0) begin n_err++; $display("FAIL frm_idle: got err %0d ack %b exp 0 0", err_cnt, ack_valid); end
    send_word(32'h0, 1'b1, 1'b0);
    send_word(word_k(1, 0), 1'b0, 1'b0);
    send_word(word_k(2, 0), 1'b0, 1'b1);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b11, 12'hFFF} || err_cnt !== 8'd1) begin n_err++; $display("FAIL frm_early_eop: got %b/%b/%h err %0d", ack_valid, ack_nak, ack_seq, err_cnt); end
    send_word(32'h0, 1'b1, 1'b0);
    send_word(word_k(1, 0), 1'b0, 1'b0);
    send_frame(12'd0, 32'h0, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || tlp_data !== exp_tlp(32'h0) || err_cnt !== 8'd2 || ack_seq !== 12'd0) begin n_err++; $display("FAIL frm_restart: got v %b err %0d seq %h", tlp_valid, err_cnt, ack_seq); end
    send_body(12'd1, 32'h0);
    send_word(exp_xor(12'd1, 32'h0), 1'b0, 1'b0);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b11, 12'd0} || err_cnt !== 8'd3 || tlp_valid !== 1'b0) begin n_err++; $display("FAIL frm_no_eop: got %b/%b/%h err %0d v %b", ack_valid, ack_nak, ack_seq, err_cnt, tlp_valid); end
    send_frame(12'd1, 32'h0, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || ack_seq !== 12'd1 || ack_nak !== 1'b0) begin n_err++; $display("FAIL frm_after: got v %b seq %h nak %b", tlp_valid, ack_seq, ack_nak); end
  endtask

  task automatic test_stall_shadow();
    do_reset();
    ack_ready = 1'b0;
    send_frame(12'd0, 32'h0, 1'b0);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b10, 12'd0}) begin n_err++; $display("FAIL stall_first: got %b/%b/%h exp 1/0/000", ack_valid, ack_nak, ack_seq); end
    send_frame(12'd1, 32'h0, 1'b0);
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b10, 12'd0}) begin n_err++; $display("FAIL stall_hold: got %b/%b/%h exp 1/0/000", ack_valid, ack_nak, ack_seq); end
    send_frame(12'd9, 32'h0, 1'b0);
    send_frame(12'd0, 32'h0, 1'b0);
    ack_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({ack_valid, ack_nak, ack_seq} !== {2'b11, 12'd1}) begin n_err++; $display("FAIL stall_shadow: got %b/%b/%h exp 1/1/001", ack_valid, ack_nak, ack_seq); end
    @(posedge clk); #1;
    n_cmp++; if (ack_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty: got %b exp 0", ack_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int s = 0; s < 4095; s++) send_frame(12'(s), 32'h0, 1'b0);
    send_frame(12'hFFF, 32'h06060606, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || tlp_data !== exp_tlp(32'h06060606) || ack_seq !== 12'hFFF) begin n_err++; $display("FAIL wrap_4095: got v %b seq %h", tlp_valid, ack_seq); end
    send_frame(12'h000, 32'h07070707, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || tlp_data !== exp_tlp(32'h07070707) || ack_seq !== 12'h000 || ack_nak !== 1'b0) begin n_err++; $display("FAIL wrap_zero: got v %b seq %h nak %b", tlp_valid, ack_seq, ack_nak); end
  endtask

  task automatic test_ack_factor();
    int base;
    do_reset();
    base = ack3_fires;
    send_frame(12'd0, 32'h0, 1'b0);
    n_cmp++; if (ack_valid3 !== 1'b0) begin n_err++; $display("FAIL af_first: got %b exp 0", ack_valid3); end
    send_frame(12'd1, 32'h0, 1'b0);
    n_cmp++; if (ack_valid3 !== 1'b0) begin n_err++; $display("FAIL af_second: got %b exp 0", ack_valid3); end
    send_frame(12'd2, 32'h0, 1'b0);
    n_cmp++; if ({ack_valid3, ack_nak3, ack_seq3} !== {2'b10, 12'd2}) begin n_err++; $display("FAIL af_third: got %b/%b/%h exp 1/0/002", ack_valid3, ack_nak3, ack_seq3); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (ack3_fires - base !== 1) begin n_err++; $display("FAIL af_count: got %0d exp 1", ack3_fires - base); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    tlp_ready = 1'b0; ack_ready = 1'b0;
    send_frame(12'd3, 32'h0, 1'b0);
    send_frame(12'd0, 32'h0, 1'b0);
    send_word(32'h1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) send_word(word_k(k, 0), 1'b0, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || ack_valid !== 1'b1 || err_cnt !== 8'd1) begin n_err++; $display("FAIL mid_pre: got v %b ack %b err %0d", tlp_valid, ack_valid, err_cnt); end
    rst_n = 1'b0; #1;
    n_cmp++; if ({tlp_valid, ack_valid, ack_nak, ack_seq, err_cnt} !== 23'h0 || tlp_data !== 224'h0) begin n_err++; $display("FAIL mid_rst: got v %b ack %b nak %b seq %h err %0d", tlp_valid, ack_valid, ack_nak, ack_seq, err_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1; tlp_ready = 1'b1; ack_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(12'd0, 32'h08080808, 1'b0);
    n_cmp++; if (tlp_valid !== 1'b1 || tlp_data !== exp_tlp(32'h08080808) || ack_seq !== 12'd0 || ack_nak !== 1'b0) begin n_err++; $display("FAIL mid_after: got v %b seq %h nak %b", tlp_valid, ack_seq, ack_nak); end
  endtask

  task automatic test_err_saturate();
    do_reset();
    repeat (254) send_word(32'h0, 1'b1, 1'b1);
    n_cmp++; if (err_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d exp 254", err_cnt); end
    send_word(32'h0, 1'b1, 1'b1);
    n_cmp++; if (err_cnt !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d exp 255", err_cnt); end
    repeat (5) send_word(32'h0, 1'b1, 1'b1);
    n_cmp++; if (err_cnt !== 8'd255) begin n_err++; $display("FAIL sat_hold: got %0d exp 255", err_cnt); end
  endtask

  initial begin
    #3;
    test_reset();
    test_good_frame();
    test_bad_lcrc();
    test_duplicate();
    test_ahead();
    test_backpressure();
    test_framing();
    test_stall_shadow();
    test_ack_factor();
    test_reset_midframe();
    test_err_saturate();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
